// File: rtl/tdc_pkg.sv
// Shared types and helpers for the tapped-delay-line TDC channel.
`timescale 1ns/1ps
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2,
        DEAD  = 2'd3
    } tdc_state_t;

    // Bits needed to hold a ones-count of 0..taps inclusive.
    function automatic int unsigned fine_width(input int unsigned taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/tdc_capture_ctrl_popcount.sv
// Combinational ones-count of a tap vector; bubble tolerant thermometer decode.
`timescale 1ns/1ps
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter  int unsigned TAPS  = 32,
    localparam int unsigned CNT_W = fine_width(TAPS)
) (
    input  logic [TAPS-1:0]  vec,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            count = count + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/tdc_capture_ctrl.sv
// Single TDC channel: synchronises delay-line taps, detects a hit at tap 0 and
// emits one {coarse, fine} timestamp per event with arm/hold/dead sequencing.
`timescale 1ns/1ps
module tdc_capture_ctrl
    import tdc_pkg::*;
#(
    parameter  int unsigned TAPS        = 32,
    parameter  int unsigned COARSE_W    = 24,
    parameter  int unsigned DEAD_CYCLES = 4,
    parameter  int unsigned LOST_W      = 8,
    localparam int unsigned FINE_W      = fine_width(TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [TAPS-1:0]     taps,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic [LOST_W-1:0]   lost_count,
    output logic                busy
);

    localparam int unsigned DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [TAPS-1:0] s1_q;
    (* ASYNC_REG = "TRUE", keep = "true" *) logic [TAPS-1:0] s2_q;
    logic [TAPS-1:0]     s1_d, s2_d;
    logic                s2p_q, s2p_d;
    tdc_state_t          state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                ts_valid_q, ts_valid_d;
    logic [COARSE_W-1:0] ts_coarse_q, ts_coarse_d;
    logic [FINE_W-1:0]   ts_fine_q, ts_fine_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic                busy_q, busy_d;

    logic                hit;
    logic [FINE_W-1:0]   fine_now;

    tdc_popcount #(.TAPS(TAPS)) u_popcount (
        .vec   (s2_q),
        .count (fine_now)
    );

    assign hit = s2_q[0] & ~s2p_q;

    always_comb begin
        s1_d        = taps;
        s2_d        = s1_q;
        s2p_d       = s2_q[0];
        coarse_d    = coarse_q + COARSE_W'(1);
        state_d     = state_q;
        dead_d      = dead_q;
        ts_coarse_d = ts_coarse_q;
        ts_fine_d   = ts_fine_q;
        lost_d      = lost_q;

        if (hit && (state_q == HOLD || state_q == DEAD) && lost_q != '1) begin
            lost_d = lost_q + LOST_W'(1);
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ARMED;
                    coarse_d = '0;
                    lost_d   = '0;
                end
                ARMED: begin
                    if (hit) begin
                        ts_coarse_d = coarse_q;
                        ts_fine_d   = fine_now;
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (ts_ready) begin
                        dead_d  = DEAD_W'(DEAD_CYCLES);
                        state_d = (DEAD_CYCLES == 0) ? ARMED : DEAD;
                    end
                end
                DEAD: begin
                    if (dead_q <= DEAD_W'(1)) begin
                        state_d = ARMED;
                    end else begin
                        dead_d = dead_q - DEAD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        ts_valid_d = (state_d == HOLD);
        busy_d     = (state_d == HOLD) || (state_d == DEAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s2p_q       <= 1'b0;
            state_q     <= IDLE;
            coarse_q    <= '0;
            dead_q      <= '0;
            ts_valid_q  <= 1'b0;
            ts_coarse_q <= '0;
            ts_fine_q   <= '0;
            lost_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s2p_q       <= s2p_d;
            state_q     <= state_d;
            coarse_q    <= coarse_d;
            dead_q      <= dead_d;
            ts_valid_q  <= ts_valid_d;
            ts_coarse_q <= ts_coarse_d;
            ts_fine_q   <= ts_fine_d;
            lost_q      <= lost_d;
            busy_q      <= busy_d;
        end
    end

    assign ts_valid   = ts_valid_q;
    assign ts_coarse  = ts_coarse_q;
    assign ts_fine    = ts_fine_q;
    assign lost_count = lost_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Directed bench for tdc_capture_ctrl: default instance plus a narrow-coarse,
// zero-dead-time instance for the wrap case.
`timescale 1ns/1ps
module tb_tdc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ts_ready;
    logic [31:0] taps;
    logic        ts_valid;
    logic [23:0] ts_coarse;
    logic [5:0]  ts_fine;
    logic [7:0]  lost_count;
    logic        busy;

    logic        enable4;
    logic        ready4;
    logic [31:0] taps4;
    logic        valid4;
    logic [3:0]  coarse4;
    logic [5:0]  fine4;
    logic [7:0]  lost4;
    logic        busy4;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned edge_n = 0;
    int unsigned arm_edge = 0;
    int unsigned hits;
    int unsigned exp_c;

    tdc_capture_ctrl #(
        .TAPS(32), .COARSE_W(24), .DEAD_CYCLES(4), .LOST_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .taps(taps),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
        .ts_fine(ts_fine), .lost_count(lost_count), .busy(busy)
    );

    tdc_capture_ctrl #(
        .TAPS(32), .COARSE_W(4), .DEAD_CYCLES(0), .LOST_W(8)
    ) dut4 (
        .clk(clk), .rst(rst), .enable(enable4), .taps(taps4),
        .ts_valid(valid4), .ts_ready(ready4), .ts_coarse(coarse4),
        .ts_fine(fine4), .lost_count(lost4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Return taps low long enough to clear sync stages and dead time, then
    // present a rising code; the load edge is the last tick.
    task automatic apply_event(input logic [31:0] v);
        taps = '0;
        repeat (6) tick();
        taps = v;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ts_ready = 1'b0; taps = '0;
        enable4 = 1'b0; ready4 = 1'b0; taps4 = '0;
        repeat (3) tick();
        chk("rst_valid", ts_valid, 0);
        chk("rst_coarse", ts_coarse, 0);
        chk("rst_fine", ts_fine, 0);
        chk("rst_lost", lost_count, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // First event: arm, then hit three edges later
        enable = 1'b1; ts_ready = 1'b1;
        tick(); arm_edge = edge_n;
        taps = 32'h0000_00FF;
        tick(); chk("lat_e1_valid", ts_valid, 0);
        tick(); chk("lat_e2_valid", ts_valid, 0);
        tick();
        chk("ev1_valid", ts_valid, 1);
        chk("ev1_coarse", ts_coarse, 2);
        chk("ev1_fine", ts_fine, 8);
        chk("ev1_lost", lost_count, 0);
        tick();
        chk("ev1_xfer_valid", ts_valid, 0);
        chk("dead_busy0", busy, 1);
        for (int i = 1; i < 4; i++) begin
            tick(); chk("dead_busy", busy, 1);
        end
        tick(); chk("dead_end_busy", busy, 0);

        // Bubble and full-scale codes
        apply_event(32'h0000_0F7F);
        exp_c = edge_n - 1 - arm_edge;
        chk("bubble_valid", ts_valid, 1);
        chk("bubble_fine", ts_fine, 11);
        chk("bubble_coarse", ts_coarse, exp_c);
        tick(); chk("bubble_xfer", ts_valid, 0);
        apply_event(32'hFFFF_FFFF);
        chk("ones_valid", ts_valid, 1);
        chk("ones_fine", ts_fine, 32);
        tick(); chk("ones_xfer", ts_valid, 0);

        // Backpressure with three further hits while holding
        ts_ready = 1'b0;
        apply_event(32'h0000_0007);
        exp_c = edge_n - 1 - arm_edge;
        chk("bp_valid", ts_valid, 1);
        chk("bp_fine", ts_fine, 3);
        for (int k = 0; k < 3; k++) begin
            taps = '0; repeat (3) tick();
            taps = 32'h0000_0007; repeat (3) tick();
            chk("bp_hold_valid", ts_valid, 1);
            chk("bp_hold_coarse", ts_coarse, exp_c);
            chk("bp_hold_fine", ts_fine, 3);
        end
        repeat (2) tick();
        chk("bp_lost", lost_count, 3);
        ts_ready = 1'b1;
        tick(); chk("bp_xfer", ts_valid, 0);
        hits = 0;
        repeat (8) begin
            tick();
            if (ts_valid) hits++;
        end
        chk("bp_single_xfer", hits, 0);
        chk("bp_lost_after", lost_count, 3);

        // Lost counter saturation
        ts_ready = 1'b0;
        taps = '0; repeat (3) tick();
        for (int n = 0; n < 300; n++) begin
            taps = 32'h1; tick();
            taps = '0;    tick();
        end
        chk("sat_lost", lost_count, 255);
        chk("sat_valid", ts_valid, 1);
        enable = 1'b0;
        tick();
        chk("dis_valid", ts_valid, 0);
        chk("dis_busy", busy, 0);
        chk("dis_lost_kept", lost_count, 255);
        enable = 1'b1;
        tick(); arm_edge = edge_n;
        chk("rearm_lost", lost_count, 0);
        apply_event(32'h0000_00FF);
        chk("rearm_valid", ts_valid, 1);
        chk("rearm_coarse", ts_coarse, 8);

        // Drop enable while holding an unacknowledged timestamp
        enable = 1'b0;
        tick();
        chk("drop_valid", ts_valid, 0);
        chk("drop_busy", busy, 0);

        // Asynchronous reset in dead time
        enable = 1'b1; ts_ready = 1'b1;
        tick();
        apply_event(32'h0000_0003);
        chk("rd_valid", ts_valid, 1);
        tick();
        chk("rd_in_dead_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rd_valid0", ts_valid, 0);
        chk("rd_coarse0", ts_coarse, 0);
        chk("rd_fine0", ts_fine, 0);
        chk("rd_lost0", lost_count, 0);
        chk("rd_busy0", busy, 0);
        enable = 1'b0; taps = '0;
        tick();
        rst = 1'b0;
        tick();

        // Narrow coarse counter wrap, zero dead time
        enable4 = 1'b1; ready4 = 1'b1;
        tick();
        repeat (13) tick();
        taps4 = 32'h1;
        repeat (3) tick();
        chk("wrap_valid1", valid4, 1);
        chk("wrap_coarse15", coarse4, 15);
        taps4 = '0;
        tick();
        chk("wrap_xfer", valid4, 0);
        chk("wrap_nodead_busy", busy4, 0);
        taps4 = 32'h1;
        repeat (3) tick();
        chk("wrap_valid2", valid4, 1);
        chk("wrap_coarse3", coarse4, 3);
        chk("wrap_fine", fine4, 1);
        chk("wrap_lost", lost4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
